exc_flush_ctrl: RTL and testbench

EXC_FLUSH_CTRL -- requirements
Module: exc_flush_ctrl

---
 rtl/exc_flush_ctrl.sv | 97 +++++++++
 tb/tb_exc_flush_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/exc_flush_ctrl.sv
// Exception / eret flush and redirect controller.
// Turns WB-stage exception/eret events into a flush pulse plus a held PC redirect.
module exc_flush_ctrl #(
    parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_ex,
    input  logic        ws_eret,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    output logic        flush_o,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        fs_redirect_ready,
    output logic        int_req_o,
    output logic        busy_o,
    output logic [15:0] ex_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        REDIR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        first_q, first_d;
    logic [31:0] pc_q, pc_d;
    logic        int_q, int_d;
    logic [15:0] cnt_q, cnt_d;

    logic event_in;
    logic take;
    logic pend;

    assign event_in = ws_ex | ws_eret;
    assign take     = (state_q == IDLE) & event_in;
    assign pend     = cp0_status[0] & ~cp0_status[1]
                    & (|(cp0_status[15:8] & cp0_cause[15:8]));

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            pc_q    <= EX_ENTRY;
            int_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            pc_q    <= pc_d;
            int_q   <= int_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-datapath logic; events ignored outside IDLE
    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        pc_d    = pc_q;
        int_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                int_d = pend & ~event_in;
                if (take) begin
                    state_d = REDIR;
                    first_d = 1'b1;
                    pc_d    = ws_ex ? EX_ENTRY : cp0_epc;
                    if (cnt_q != 16'hffff) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            REDIR: begin
                if (fs_redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        busy_o         = (state_q == REDIR);
        redirect_valid = (state_q == REDIR);
        flush_o        = first_q;
        redirect_pc    = pc_q;
        int_req_o      = int_q;
        ex_cnt_o       = cnt_q;
    end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Testbench for exc_flush_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_exc_flush_ctrl;

    localparam logic [31:0] ENTRY = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_ex;
    logic        ws_eret;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic        flush_o;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fs_redirect_ready;
    logic        int_req_o;
    logic        busy_o;
    logic [15:0] ex_cnt_o;

    int checks = 0;
    int errors = 0;

    exc_flush_ctrl #(.EX_ENTRY(ENTRY)) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_ex             (ws_ex),
        .ws_eret           (ws_eret),
        .cp0_epc           (cp0_epc),
        .cp0_status        (cp0_status),
        .cp0_cause         (cp0_cause),
        .flush_o           (flush_o),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fs_redirect_ready (fs_redirect_ready),
        .int_req_o         (int_req_o),
        .busy_o            (busy_o),
        .ex_cnt_o          (ex_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model: a redirect in flight, its age, the target, the tally
    bit          started = 0;
    bit          m_inflight;
    int          m_age;
    logic [31:0] m_target;
    bit          m_int;
    int          m_tally;

    task automatic model_step();
        bit ev;
        bit pend;
        ev   = ws_ex || ws_eret;
        pend = cp0_status[0] && !cp0_status[1]
               && ((cp0_status[15:8] & cp0_cause[15:8]) != 8'd0);
        if (reset) begin
            m_inflight = 0;
            m_age      = 0;
            m_target   = ENTRY;
            m_int      = 0;
            m_tally    = 0;
            started    = 1;
        end else if (!m_inflight) begin
            m_int = pend && !ev;
            if (ev) begin
                m_inflight = 1;
                m_age      = 0;
                m_target   = ws_ex ? ENTRY : cp0_epc;
                m_tally    = (m_tally + 1 > 65535) ? 65535 : m_tally + 1;
            end
        end else begin
            m_int = 0;
            m_age = m_age + 1;
            if (fs_redirect_ready) m_inflight = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("m_busy", {31'd0, busy_o}, {31'd0, m_inflight});
            check("m_valid", {31'd0, redirect_valid}, {31'd0, m_inflight});
            check("m_flush", {31'd0, flush_o},
                  {31'd0, m_inflight && m_age == 0});
            check("m_pc", redirect_pc, m_target);
            check("m_int", {31'd0, int_req_o}, {31'd0, m_int});
            check("m_cnt", {16'd0, ex_cnt_o}, m_tally[31:0]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset = 1; ws_ex = 0; ws_eret = 0; cp0_epc = 0;
        cp0_status = 0; cp0_cause = 0; fs_redirect_ready = 1;
        tick(); tick();
        check("rst_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_pc", redirect_pc, 32'hbfc00380);
        check("rst_cnt", {16'd0, ex_cnt_o}, 32'd0);
        reset = 0;

        // Exception, ready held high
        ws_ex = 1; tick();
        check("ex_flush", {31'd0, flush_o}, 32'd1);
        check("ex_valid", {31'd0, redirect_valid}, 32'd1);
        check("ex_pc", redirect_pc, 32'hbfc00380);
        check("ex_cnt", {16'd0, ex_cnt_o}, 32'd1);
        ws_ex = 0; tick();
        check("ex_idle", {31'd0, busy_o}, 32'd0);

        // Eret with ready low for three cycles
        fs_redirect_ready = 0; cp0_epc = 32'hbfc00100; ws_eret = 1; tick();
        check("eret_flush1", {31'd0, flush_o}, 32'd1);
        check("eret_pc1", redirect_pc, 32'hbfc00100);
        ws_eret = 0; cp0_epc = 32'h0000_0055; tick();
        check("eret_flush2", {31'd0, flush_o}, 32'd0);
        check("eret_pc2", redirect_pc, 32'hbfc00100);
        tick();
        check("eret_pc3", redirect_pc, 32'hbfc00100);
        tick();
        check("eret_pc4", redirect_pc, 32'hbfc00100);
        check("eret_valid4", {31'd0, redirect_valid}, 32'd1);
        fs_redirect_ready = 1; tick();
        check("eret_idle", {31'd0, redirect_valid}, 32'd0);
        check("eret_cnt", {16'd0, ex_cnt_o}, 32'd2);

        // Simultaneous exception and eret
        ws_ex = 1; ws_eret = 1; cp0_epc = 32'h1234; tick();
        check("both_pc", redirect_pc, 32'hbfc00380);
        ws_ex = 0; ws_eret = 0; tick();

        // Interrupt request
        cp0_status = 32'h0000_0401; cp0_cause = 32'h0000_0400; tick();
        check("int_set", {31'd0, int_req_o}, 32'd1);
        cp0_status = 32'h0000_0403; tick();
        check("int_exl", {31'd0, int_req_o}, 32'd0);
        cp0_status = 32'h0000_0401; tick();
        check("int_reset", {31'd0, int_req_o}, 32'd1);
        ws_ex = 1; tick();
        check("int_redir", {31'd0, int_req_o}, 32'd0);
        check("int_busy", {31'd0, busy_o}, 32'd1);
        ws_ex = 0; cp0_status = 0; cp0_cause = 0; tick();
        check("cnt4", {16'd0, ex_cnt_o}, 32'd4);

        // Events in REDIR are ignored; reset aborts redirect
        fs_redirect_ready = 0; ws_ex = 1; tick();
        check("hold_cnt5", {16'd0, ex_cnt_o}, 32'd5);
        tick();
        check("ign_cnt", {16'd0, ex_cnt_o}, 32'd5);
        check("ign_flush", {31'd0, flush_o}, 32'd0);
        ws_ex = 0; reset = 1; tick();
        check("abort_valid", {31'd0, redirect_valid}, 32'd0);
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_cnt", {16'd0, ex_cnt_o}, 32'd0);
        check("abort_pc", redirect_pc, 32'hbfc00380);
        reset = 0;

        // Randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 4000; i++) begin
            ws_ex             = ($urandom_range(0, 7) == 0);
            ws_eret           = ($urandom_range(0, 5) == 0);
            fs_redirect_ready = ($urandom_range(0, 2) != 0);
            cp0_epc           = $urandom;
            cp0_status        = {16'd0, 8'($urandom), 6'd0,
                                 2'($urandom)};
            cp0_cause         = {16'd0, 8'($urandom), 8'd0};
            reset             = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 0; ws_ex = 0; ws_eret = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
